// File: rtl/stopwatch_counter.sv
// MM:SS BCD stopwatch core: run/pause/adjust FSM, 2 Hz field adjust, blink masking.
// Optional lap-hold display freeze is built when STOPWATCH_LAP_EN is defined.
module stopwatch_counter #(
  parameter int MAX_MIN = 59
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tick_1hz,
  input  logic       i_tick_2hz,
  input  logic       i_tick_blink,
  input  logic       i_pause,
  input  logic       i_adj,
  input  logic       i_sel,
  input  logic       i_lap,
  output logic [3:0] o_min_tens,
  output logic [3:0] o_min_ones,
  output logic [3:0] o_sec_tens,
  output logic [3:0] o_sec_ones,
  output logic [3:0] o_blank,
  output logic       o_paused,
  output logic       o_wrap
);

  localparam logic [3:0] MAX_T = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_O = 4'(MAX_MIN % 10);

  typedef enum logic [1:0] {S_RUN, S_PAUSED, S_ADJUST} state_t;

  state_t     r_state, w_state_nx;
  logic       r_prev, w_prev_nx;
  logic       r_phase, w_phase_nx;
  logic       r_pause_d, w_pause_edge;
  logic [3:0] r_mt, r_mo, r_st, r_so;
  logic [3:0] w_mt_nx, w_mo_nx, w_st_nx, w_so_nx;
  logic       w_inc_run, w_inc_sec, w_inc_min, w_sec_max, w_min_max;
  logic       r_wrap, w_wrap_nx;
  logic [3:0] r_blank, w_blank_nx;
  logic       r_paused, w_paused_nx;

  assign w_pause_edge = i_pause & ~r_pause_d;
  assign w_phase_nx   = r_phase ^ i_tick_blink;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_RUN;
      r_prev  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_prev  <= w_prev_nx;
    end
  end

  // Next-state logic: adj dominates, pause edges only act outside ADJUST
  always_comb begin
    w_state_nx = r_state;
    w_prev_nx  = r_prev;
    if (i_adj) begin
      w_state_nx = S_ADJUST;
      if (r_state != S_ADJUST) w_prev_nx = (r_state == S_PAUSED);
    end else begin
      case (r_state)
        S_ADJUST: w_state_nx = r_prev ? S_PAUSED : S_RUN;
        S_RUN:    if (w_pause_edge) w_state_nx = S_PAUSED;
        S_PAUSED: if (w_pause_edge) w_state_nx = S_RUN;
        default:  w_state_nx = S_RUN;
      endcase
    end
  end

  // Counter datapath: carry from seconds into minutes only in RUN
  assign w_inc_run = (r_state == S_RUN) & ~i_adj & i_tick_1hz;
  assign w_sec_max = (r_st == 4'd5) && (r_so == 4'd9);
  assign w_min_max = (r_mt == MAX_T) && (r_mo == MAX_O);
  assign w_inc_sec = w_inc_run | (i_adj & i_tick_2hz & i_sel);
  assign w_inc_min = (w_inc_run & w_sec_max) | (i_adj & i_tick_2hz & ~i_sel);

  always_comb begin
    w_mt_nx = r_mt;
    w_mo_nx = r_mo;
    w_st_nx = r_st;
    w_so_nx = r_so;
    if (w_inc_sec) begin
      if (r_so == 4'd9) begin
        w_so_nx = 4'd0;
        w_st_nx = (r_st == 4'd5) ? 4'd0 : r_st + 4'd1;
      end else begin
        w_so_nx = r_so + 4'd1;
      end
    end
    if (w_inc_min) begin
      if (w_min_max) begin
        w_mt_nx = 4'd0;
        w_mo_nx = 4'd0;
      end else if (r_mo == 4'd9) begin
        w_mo_nx = 4'd0;
        w_mt_nx = r_mt + 4'd1;
      end else begin
        w_mo_nx = r_mo + 4'd1;
      end
    end
  end

  // Output logic, registered below
  always_comb begin
    w_wrap_nx   = w_inc_run & w_sec_max & w_min_max;
    w_paused_nx = (w_state_nx == S_PAUSED);
    w_blank_nx  = 4'b0000;
    if (w_state_nx == S_ADJUST && w_phase_nx)
      w_blank_nx = i_sel ? 4'b0011 : 4'b1100;
  end

  // The edge detector follows its input during reset so a level held
  // across reset release is not seen as a fresh press.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mt      <= 4'd0;
      r_mo      <= 4'd0;
      r_st      <= 4'd0;
      r_so      <= 4'd0;
      r_phase   <= 1'b0;
      r_pause_d <= i_pause;
      r_wrap    <= 1'b0;
      r_blank   <= 4'b0000;
      r_paused  <= 1'b0;
    end else begin
      r_mt      <= w_mt_nx;
      r_mo      <= w_mo_nx;
      r_st      <= w_st_nx;
      r_so      <= w_so_nx;
      r_phase   <= w_phase_nx;
      r_pause_d <= i_pause;
      r_wrap    <= w_wrap_nx;
      r_blank   <= w_blank_nx;
      r_paused  <= w_paused_nx;
    end
  end

  assign o_wrap   = r_wrap;
  assign o_blank  = r_blank;
  assign o_paused = r_paused;

`ifdef STOPWATCH_LAP_EN
  logic       r_lap_d, r_hold, w_hold_nx, w_lap_edge;
  logic [3:0] r_dmt, r_dmo, r_dst, r_dso;

  assign w_lap_edge = i_lap & ~r_lap_d;
  // Hold is dropped whenever ADJUST is active so adjustment shows live digits
  assign w_hold_nx  = (i_adj || r_state == S_ADJUST) ? 1'b0 : (r_hold ^ w_lap_edge);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lap_d <= i_lap;
      r_hold  <= 1'b0;
      r_dmt   <= 4'd0;
      r_dmo   <= 4'd0;
      r_dst   <= 4'd0;
      r_dso   <= 4'd0;
    end else begin
      r_lap_d <= i_lap;
      r_hold  <= w_hold_nx;
      if (!w_hold_nx) begin
        r_dmt <= w_mt_nx;
        r_dmo <= w_mo_nx;
        r_dst <= w_st_nx;
        r_dso <= w_so_nx;
      end
    end
  end

  assign o_min_tens = r_dmt;
  assign o_min_ones = r_dmo;
  assign o_sec_tens = r_dst;
  assign o_sec_ones = r_dso;
`else
  logic w_lap_unused;
  assign w_lap_unused = i_lap;

  assign o_min_tens = r_mt;
  assign o_min_ones = r_mo;
  assign o_sec_tens = r_st;
  assign o_sec_ones = r_so;
`endif

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter: directed scenarios then random stimulus, all
// checked each cycle against an arithmetic (total-seconds) reference model.
module tb_stopwatch_counter;
  localparam int MAXM = 59;

  logic clk = 1'b0;
  logic rst, t1, t2, tbk, pause, adj, sel, lap;
  logic [3:0] mt, mo, st, so, blank;
  logic paused, wrap;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  int m_min, m_sec, d_min, d_sec;
  bit m_pausedst, m_adj, m_prev, m_phase, m_pprev, m_lprev, m_hold, m_wrap;
  logic [3:0] m_blank;

  stopwatch_counter #(.MAX_MIN(MAXM)) dut (
    .i_clk(clk), .i_rst(rst), .i_tick_1hz(t1), .i_tick_2hz(t2), .i_tick_blink(tbk),
    .i_pause(pause), .i_adj(adj), .i_sel(sel), .i_lap(lap),
    .o_min_tens(mt), .o_min_ones(mo), .o_sec_tens(st), .o_sec_ones(so),
    .o_blank(blank), .o_paused(paused), .o_wrap(wrap));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    bit edge_p, edge_l, was_adj;
    int total;
    if (rst) begin
      m_min = 0; m_sec = 0; m_pausedst = 0; m_adj = 0; m_prev = 0; m_phase = 0;
      m_pprev = pause; m_lprev = lap; m_hold = 0; m_wrap = 0; m_blank = 0;
      d_min = 0; d_sec = 0;
      return;
    end
    edge_p = pause && !m_pprev; m_pprev = pause;
    edge_l = lap && !m_lprev;   m_lprev = lap;
    m_wrap = 0;
    was_adj = m_adj;
    if (tbk) m_phase = !m_phase;
    if (adj) begin
      if (!m_adj) m_prev = m_pausedst;
      m_adj = 1;
      if (t2) begin
        if (sel) m_sec = (m_sec + 1) % 60;
        else     m_min = (m_min + 1) % (MAXM + 1);
      end
    end else if (m_adj) begin
      m_adj = 0;
      m_pausedst = m_prev;
    end else begin
      if (!m_pausedst && t1) begin
        total = m_min * 60 + m_sec + 1;
        if (total == (MAXM + 1) * 60) begin total = 0; m_wrap = 1; end
        m_min = total / 60;
        m_sec = total % 60;
      end
      if (edge_p) m_pausedst = !m_pausedst;
    end
    m_blank = (m_adj && m_phase) ? (sel ? 4'b0011 : 4'b1100) : 4'b0000;
`ifdef STOPWATCH_LAP_EN
    if (adj || was_adj) m_hold = 0;
    else if (edge_l) m_hold = !m_hold;
    if (!m_hold) begin d_min = m_min; d_sec = m_sec; end
`else
    d_min = m_min; d_sec = m_sec;
`endif
  endtask

  // One clock: apply ticks, advance model at the edge, compare #1 later.
  task automatic step(input logic a1, input logic a2, input logic ab);
    t1 = a1; t2 = a2; tbk = ab;
    @(posedge clk);
    model_update();
    #1;
    chk("min_tens", 8'(mt), 8'(d_min / 10));
    chk("min_ones", 8'(mo), 8'(d_min % 10));
    chk("sec_tens", 8'(st), 8'(d_sec / 10));
    chk("sec_ones", 8'(so), 8'(d_sec % 10));
    chk("blank",    8'(blank), 8'(m_blank));
    chk("paused",   8'(paused), 8'(!m_adj && m_pausedst));
    chk("wrap",     8'(wrap), 8'(m_wrap));
    t1 = 0; t2 = 0; tbk = 0;
  endtask

  task automatic chk_time(input string tag, input int mm, input int ss);
    chk({tag, "_mt"}, 8'(mt), 8'(mm / 10));
    chk({tag, "_mo"}, 8'(mo), 8'(mm % 10));
    chk({tag, "_st"}, 8'(st), 8'(ss / 10));
    chk({tag, "_so"}, 8'(so), 8'(ss % 10));
  endtask

  initial begin
    rst = 1; t1 = 0; t2 = 0; tbk = 0; pause = 1; adj = 0; sel = 0; lap = 1;
    #2;
    // reset with pause/lap held high, then release without toggling
    repeat (3) step(0, 0, 0);
    chk_time("reset", 0, 0);
    chk("reset_blank", 8'(blank), 8'd0);
    rst = 0;
    repeat (3) step(0, 0, 0);
    chk("held_pause_no_toggle", 8'(paused), 8'd0);
    pause = 0; lap = 0;
    step(0, 0, 0);

    // 61 seconds in RUN
    repeat (61) begin step(1, 0, 0); step(0, 0, 0); end
    chk_time("run61", 1, 1);
    chk("run61_paused", 8'(paused), 8'd0);
    chk("run61_blank", 8'(blank), 8'd0);

    // preload 59:58 via adjust, then wrap
    adj = 1; sel = 0;
    repeat (58) step(0, 1, 0);
    sel = 1;
    repeat (57) step(0, 1, 0);
    chk_time("preload", 59, 58);
    adj = 0;
    step(0, 0, 0);
    step(1, 0, 0);
    chk("pre_wrap", 8'(wrap), 8'd0);
    step(1, 0, 0);
    chk_time("wrapped", 0, 0);
    chk("wrap_pulse", 8'(wrap), 8'd1);
    step(0, 0, 0);
    chk("wrap_one_cycle", 8'(wrap), 8'd0);

    // pause edge coinciding with a tick at 00:10
    repeat (10) step(1, 0, 0);
    pause = 1;
    step(1, 0, 0);
    chk_time("pause_tick", 0, 11);
    chk("pause_now", 8'(paused), 8'd1);
    pause = 0;
    repeat (3) step(1, 0, 0);
    chk_time("paused_hold", 0, 11);
    pause = 1;
    step(0, 0, 0);
    chk("resume", 8'(paused), 8'd0);
    pause = 0;

    // adjust seconds from 00:58, 1 Hz ignored, blink mask
    repeat (47) step(1, 0, 0);
    adj = 1; sel = 1;
    repeat (3) step(1, 1, 0);
    chk_time("adj_sec", 0, 1);
    chk("adj_no_wrap", 8'(wrap), 8'd0);
    step(0, 0, 1);
    chk("blank_sec", 8'(blank), 8'b0011);
    sel = 0;
    step(0, 0, 0);
    chk("blank_min", 8'(blank), 8'b1100);
    adj = 0;
    step(0, 0, 0);
    chk("adj_exit_blank", 8'(blank), 8'd0);
    chk("adj_exit_run", 8'(paused), 8'd0);

    // 12:34 then reset mid-adjust
    adj = 1; sel = 0;
    repeat (12) step(0, 1, 0);
    sel = 1;
    repeat (33) step(0, 1, 0);
    chk_time("preset", 12, 34);
    rst = 1;
    step(0, 0, 0);
    chk_time("rst_mid_adj", 0, 0);
    chk("rst_blank", 8'(blank), 8'd0);
    chk("rst_paused", 8'(paused), 8'd0);
    rst = 0; adj = 0;
    step(0, 0, 0);

`ifdef STOPWATCH_LAP_EN
    repeat (20) step(1, 0, 0);
    lap = 1;
    step(0, 0, 0);
    repeat (5) step(1, 0, 0);
    chk_time("lap_hold", 0, 20);
    lap = 0;
    step(0, 0, 0);
    lap = 1;
    step(0, 0, 0);
    chk_time("lap_release", 0, 25);
    lap = 0;
    step(0, 0, 0);
`endif

    // randomized stimulus against the model
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 7) == 0)  pause = ~pause;
      if ($urandom_range(0, 39) == 0) adj = ~adj;
      if ($urandom_range(0, 9) == 0)  sel = ~sel;
      if ($urandom_range(0, 11) == 0) lap = ~lap;
      step(($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
